// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display scanner and its decoder.
package seg7_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'b000_0000;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_display_scanner_decoder.sv
// BCD to 7-segment decoder, segment order {g,f,e,d,c,b,a}, active-high.
// Codes 10..15 decode to all segments off.
module seg7_display_scanner_decoder
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] counter,
  output logic [6:0]         segments
);

  // Pure lookup from digit value to segment pattern
  always_comb begin
    segments = SEG_BLANK;
    case (counter)
      4'd0: segments = 7'h3F;
      4'd1: segments = 7'h06;
      4'd2: segments = 7'h5B;
      4'd3: segments = 7'h4F;
      4'd4: segments = 7'h66;
      4'd5: segments = 7'h6D;
      4'd6: segments = 7'h7D;
      4'd7: segments = 7'h07;
      4'd8: segments = 7'h7F;
      4'd9: segments = 7'h6F;
      default: segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_display_scanner.sv
// Multiplexed 7-segment display scanner with valid/ready digit input.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_BLANK | dead time between slots, every digit enable inactive
//   ST_SHOW  | digit_en[idx] active for REFRESH_DIV cycles
//
// New digit values are staged in a pending buffer and only copied into the
// displayed (active) set when the last digit's SHOW slot ends, so a frame is
// never drawn from two different values.
module seg7_display_scanner
  import seg7_pkg::*;
#(
  parameter int          NUM_DIGITS   = 4,
  parameter logic [23:0] REFRESH_DIV  = 24'd10_000,
  parameter logic [7:0]  BLANK_CYCLES = 8'd50,
  parameter logic        COMMON_ANODE = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          digits_valid,
  output logic                          digits_ready,
  input  logic                          lz_blank,
  output logic [6:0]                    segments,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         digit_en
);

  localparam int MAX_CNT = (int'(REFRESH_DIV) > int'(BLANK_CYCLES)) ?
                           int'(REFRESH_DIV) : int'(BLANK_CYCLES);
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(int'(REFRESH_DIV) - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST =
    CNT_W'((BLANK_CYCLES == 8'd0) ? 0 : int'(BLANK_CYCLES) - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic             NO_DEAD    = (BLANK_CYCLES == 8'd0);

  scan_state_t                   state;
  logic [CNT_W-1:0]              cnt;
  logic [IDX_W-1:0]              idx;

  logic [DIGIT_W*NUM_DIGITS-1:0] pend_digits, act_digits;
  logic [NUM_DIGITS-1:0]         pend_dp, act_dp;
  logic                          pending_full, act_valid;

  logic                          slot_done, frame_boundary, accept;
  logic [DIGIT_W-1:0]            cur_digit;
  logic                          cur_dp, lz_hit, zero_run;
  logic [6:0]                    dec_seg, seg_nx;
  logic                          dp_nx, show;
  logic [NUM_DIGITS-1:0]         en_nx;

  assign show           = (state == ST_SHOW);
  assign slot_done      = show ? (cnt == SHOW_LAST) : (NO_DEAD || (cnt == BLANK_LAST));
  assign frame_boundary = show && slot_done && (idx == IDX_LAST);
  assign accept         = digits_valid && !pending_full;
  assign digits_ready   = ~pending_full;

  // Slot timer and scan FSM; the counter restarts on every state entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else if (slot_done) begin
      cnt <= '0;
      if (show) begin
        idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        state <= NO_DEAD ? ST_SHOW : ST_BLANK;
      end else begin
        state <= ST_SHOW;
      end
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Pending capture on handshake, promotion to the active set at the frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_digits  <= '0;
      pend_dp      <= '0;
      pending_full <= 1'b0;
      act_digits   <= '0;
      act_dp       <= '0;
      act_valid    <= 1'b0;
    end else if (frame_boundary && pending_full) begin
      act_digits   <= pend_digits;
      act_dp       <= pend_dp;
      act_valid    <= 1'b1;
      pending_full <= 1'b0;
    end else if (accept) begin
      pend_digits  <= digits_in;
      pend_dp      <= dp_in;
      pending_full <= 1'b1;
    end
  end

  // Select the digit at idx and find whether it falls inside the leading-zero run
  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    lz_hit    = 1'b0;
    zero_run  = 1'b1;
    en_nx     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (act_digits[i*DIGIT_W +: DIGIT_W] == '0);
      if (IDX_W'(i) == idx) begin
        cur_digit = act_digits[i*DIGIT_W +: DIGIT_W];
        cur_dp    = act_dp[i];
        lz_hit    = zero_run && (i != 0);
        en_nx[i]  = show;
      end
    end
  end

  seg7_display_scanner_decoder u_decoder (
    .counter  (cur_digit),
    .segments (dec_seg)
  );

  // Active-high pin values before the polarity stage
  always_comb begin
    seg_nx = SEG_BLANK;
    dp_nx  = 1'b0;
    if (show && act_valid) begin
      dp_nx = cur_dp;
      if (!(lz_blank && lz_hit)) begin
        seg_nx = dec_seg;
      end
    end
  end

  // Registered output stage with common-anode inversion; reset parks pins inactive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segments <= {7{COMMON_ANODE}};
      dp       <= COMMON_ANODE;
      digit_en <= {NUM_DIGITS{COMMON_ANODE}};
    end else begin
      segments <= seg_nx ^ {7{COMMON_ANODE}};
      dp       <= dp_nx ^ COMMON_ANODE;
      digit_en <= en_nx ^ {NUM_DIGITS{COMMON_ANODE}};
    end
  end

endmodule
